// File: rtl/sprite_compositor.sv
// Two-stage pixel compositor for the Pac-Man VGA path: merges sprite layers with
// wall, food and score-text layers and produces registered VGA colour plus a layer tag.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int COLOR_W = 8,
    parameter int MAZE_H = 352,
    parameter int FLASH_FRAMES = 16,
    parameter logic [3*COLOR_W-1:0] TRANSPARENT_RGB = 24'h000000,
    parameter logic [3*COLOR_W-1:0] FRIGHT_RGB = 24'h2121FF,
    parameter logic [3*COLOR_W-1:0] FLASH_RGB = 24'hFFFFFF,
    localparam int LID_W = $clog2(NUM_SPRITES + 4)
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               frame_start,
    input  logic                               pixel_valid,
    input  logic [9:0]                         DrawX,
    input  logic [9:0]                         DrawY,
    input  logic [NUM_SPRITES-1:0]             sprite_hit,
    input  logic [NUM_SPRITES*3*COLOR_W-1:0]   sprite_rgb,
    input  logic                               is_wall,
    input  logic                               is_food,
    input  logic                               text_bit,
    input  logic                               frightened,
    input  logic                               fright_ending,
    input  logic                               level_clear,
    output logic [COLOR_W-1:0]                 VGA_R,
    output logic [COLOR_W-1:0]                 VGA_G,
    output logic [COLOR_W-1:0]                 VGA_B,
    output logic                               out_valid,
    output logic [LID_W-1:0]                   layer_id
);

    localparam int PIX_W = 3 * COLOR_W;
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);
    localparam logic [PIX_W-1:0] WALL_RGB = {{(2*COLOR_W){1'b0}}, {COLOR_W{1'b1}}};

    // Colouring depends only on the row; X is carried on the interface for symmetry.
    logic unused_drawx;
    assign unused_drawx = ^DrawX;

    logic [CNT_W-1:0] frame_cnt_reg;
    logic             flash_phase_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt_reg   <= '0;
            flash_phase_reg <= 1'b0;
        end else if (frame_start) begin
            if (frame_cnt_reg == CNT_W'(FLASH_FRAMES - 1)) begin
                frame_cnt_reg   <= '0;
                flash_phase_reg <= ~flash_phase_reg;
            end else begin
                frame_cnt_reg <= frame_cnt_reg + 1'b1;
            end
        end
    end

    logic                             s1_valid_reg;
    logic [9:0]                       s1_drawy_reg;
    logic [NUM_SPRITES-1:0]           s1_hit_reg;
    logic [NUM_SPRITES*PIX_W-1:0]     s1_rgb_reg;
    logic                             s1_wall_reg;
    logic                             s1_food_reg;
    logic                             s1_text_reg;
    logic                             s1_fright_reg;
    logic                             s1_ending_reg;
    logic                             s1_lc_reg;
    logic                             s1_phase_reg;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= pixel_valid;
        end
    end

    // Mode bits and phase travel with the pixel so a mid-line change never tears it.
    always_ff @(posedge Clk) begin
        s1_drawy_reg  <= DrawY;
        s1_hit_reg    <= sprite_hit;
        s1_rgb_reg    <= sprite_rgb;
        s1_wall_reg   <= is_wall;
        s1_food_reg   <= is_food;
        s1_text_reg   <= text_bit;
        s1_fright_reg <= frightened;
        s1_ending_reg <= fright_ending;
        s1_lc_reg     <= level_clear;
        s1_phase_reg  <= flash_phase_reg;
    end

    logic [NUM_SPRITES-1:0] opaque;
    logic [PIX_W-1:0]       sprite_col [NUM_SPRITES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_sprite
            logic [PIX_W-1:0] rom_col;
            assign rom_col    = s1_rgb_reg[gi*PIX_W +: PIX_W];
            assign opaque[gi] = s1_hit_reg[gi] && (rom_col != TRANSPARENT_RGB);
            if (gi == 0) begin : g_pacman
                assign sprite_col[gi] = rom_col;
            end else begin : g_ghost
                assign sprite_col[gi] = !s1_fright_reg ? rom_col :
                                        (s1_ending_reg && s1_phase_reg) ? FLASH_RGB : FRIGHT_RGB;
            end
        end
    endgenerate

    logic             in_maze;
    logic [PIX_W-1:0] pix_next;
    logic [LID_W-1:0] layer_next;

    assign in_maze = ({22'd0, s1_drawy_reg} < MAZE_H);

    // Layers are applied lowest priority first so each later hit overrides.
    always_comb begin
        pix_next   = '0;
        layer_next = '0;
        if (s1_text_reg) begin
            pix_next   = FLASH_RGB;
            layer_next = LID_W'(1);
        end
        if (s1_food_reg && in_maze) begin
            pix_next   = FLASH_RGB;
            layer_next = LID_W'(2);
        end
        if (s1_wall_reg && in_maze) begin
            pix_next   = (s1_lc_reg && s1_phase_reg) ? FLASH_RGB : WALL_RGB;
            layer_next = LID_W'(3);
        end
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                pix_next   = sprite_col[i];
                layer_next = LID_W'(4 + i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
            layer_id  <= '0;
        end else begin
            out_valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                VGA_R    <= pix_next[PIX_W-1 -: COLOR_W];
                VGA_G    <= pix_next[2*COLOR_W-1 -: COLOR_W];
                VGA_B    <= pix_next[COLOR_W-1:0];
                layer_id <= layer_next;
            end else begin
                VGA_R    <= '0;
                VGA_G    <= '0;
                VGA_B    <= '0;
                layer_id <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random traffic, all checked
// cycle by cycle against a priority-order reference model with a 2-cycle delay.
module tb_sprite_compositor;

    localparam int NS = 4;
    localparam int CW = 8;
    localparam int FF = 2;
    localparam int MH = 352;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic            Reset;
    logic            frame_start;
    logic            pixel_valid;
    logic [9:0]      DrawX;
    logic [9:0]      DrawY;
    logic [NS-1:0]   sprite_hit;
    logic [NS*24-1:0] sprite_rgb;
    logic            is_wall;
    logic            is_food;
    logic            text_bit;
    logic            frightened;
    logic            fright_ending;
    logic            level_clear;
    logic [CW-1:0]   VGA_R;
    logic [CW-1:0]   VGA_G;
    logic [CW-1:0]   VGA_B;
    logic            out_valid;
    logic [2:0]      layer_id;

    sprite_compositor #(
        .NUM_SPRITES(NS),
        .COLOR_W(CW),
        .MAZE_H(MH),
        .FLASH_FRAMES(FF)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .frame_start(frame_start),
        .pixel_valid(pixel_valid),
        .DrawX(DrawX),
        .DrawY(DrawY),
        .sprite_hit(sprite_hit),
        .sprite_rgb(sprite_rgb),
        .is_wall(is_wall),
        .is_food(is_food),
        .text_bit(text_bit),
        .frightened(frightened),
        .fright_ending(fright_ending),
        .level_clear(level_clear),
        .VGA_R(VGA_R),
        .VGA_G(VGA_G),
        .VGA_B(VGA_B),
        .out_valid(out_valid),
        .layer_id(layer_id)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct packed {
        logic        v;
        logic [23:0] rgb;
        logic [2:0]  id;
    } px_t;

    // Walk the layers from highest priority down and stop at the first that shows.
    function automatic px_t ref_pixel(input int pulses);
        px_t  r;
        logic ph;
        r = '0;
        if (!pixel_valid) return r;
        r.v = 1'b1;
        ph = ((pulses / FF) % 2) == 1;
        for (int i = 0; i < NS; i++) begin
            logic [23:0] c;
            c = sprite_rgb[i*24 +: 24];
            if (sprite_hit[i] && c != 24'h000000) begin
                r.id = 3'(4 + i);
                if (i > 0 && frightened) r.rgb = (fright_ending && ph) ? 24'hFFFFFF : 24'h2121FF;
                else r.rgb = c;
                return r;
            end
        end
        if (DrawY < MH && is_wall) begin
            r.rgb = (level_clear && ph) ? 24'hFFFFFF : 24'h0000FF;
            r.id = 3'd3;
            return r;
        end
        if (DrawY < MH && is_food) begin
            r.rgb = 24'hFFFFFF;
            r.id = 3'd2;
            return r;
        end
        if (text_bit) begin
            r.rgb = 24'hFFFFFF;
            r.id = 3'd1;
        end
        return r;
    endfunction

    px_t exp_s1 = '0;
    px_t exp_out = '0;
    int  pulses = 0;

    always @(posedge Clk) begin
        if (Reset) begin
            exp_s1  <= '0;
            exp_out <= '0;
            pulses  <= 0;
        end else begin
            exp_out <= exp_s1;
            exp_s1  <= ref_pixel(pulses);
            if (frame_start) pulses <= pulses + 1;
        end
    end

    bit chk_en = 1'b0;
    always @(negedge Clk) begin
        if (chk_en) begin
            check_val("valid", 32'(out_valid), 32'(exp_out.v));
            check_val("rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, exp_out.rgb});
            check_val("layer", 32'(layer_id), 32'(exp_out.id));
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs();
        frame_start = 0; pixel_valid = 0; DrawX = '0; DrawY = '0;
        sprite_hit = '0; sprite_rgb = '0; is_wall = 0; is_food = 0; text_bit = 0;
        frightened = 0; fright_ending = 0; level_clear = 0;
    endtask

    task automatic rand_px();
        pixel_valid = ($urandom_range(0, 4) != 0);
        DrawX = 10'($urandom_range(0, 639));
        DrawY = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(345, 358)) : 10'($urandom_range(0, 479));
        sprite_hit = NS'($urandom);
        for (int i = 0; i < NS; i++) begin
            logic [23:0] c;
            c = ($urandom_range(0, 2) == 0) ? 24'h0 : 24'($urandom);
            sprite_rgb[i*24 +: 24] = c;
        end
        is_wall = 1'($urandom); is_food = 1'($urandom); text_bit = 1'($urandom);
        frightened = 1'($urandom); fright_ending = 1'($urandom); level_clear = 1'($urandom);
    endtask

    // Present the current pixel for one cycle, drain, then check the composited result.
    task automatic flush_check(input string tag, input logic [23:0] rgb, input logic [2:0] id);
        pixel_valid = 1;
        step();
        pixel_valid = 0;
        step();
        check_val({tag, "_rgb"}, {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, rgb});
        check_val({tag, "_id"}, 32'(layer_id), 32'(id));
        $display("txn %s: rgb=%02h%02h%02h layer=%0d", tag, VGA_R, VGA_G, VGA_B, layer_id);
    endtask

    task automatic pulse_frame();
        frame_start = 1;
        step();
        frame_start = 0;
    endtask

    logic [23:0] ghost_tab [4];
    int burst_cnt;

    initial begin
        Reset = 1;
        clear_inputs();
        rand_px();
        pixel_valid = 1;
        step();
        chk_en = 1;
        step();
        step();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'd0);

        // Latency after reset release.
        Reset = 0;
        clear_inputs();
        pixel_valid = 1;
        DrawY = 10'd100; is_food = 1;
        step();
        pixel_valid = 0;
        check_val("lat_c1", 32'(out_valid), 32'd0);
        step();
        check_val("lat_c2", 32'(out_valid), 32'd1);
        $display("txn latency: out_valid=%0d two cycles after first pixel", out_valid);
        step();

        clear_inputs();
        DrawY = 10'd50;
        sprite_hit = 4'b0011;
        sprite_rgb[0 +: 24] = 24'hFFFF00;
        sprite_rgb[24 +: 24] = 24'hFF0000;
        flush_check("pacman_over_ghost", 24'hFFFF00, 3'd4);
        sprite_rgb[0 +: 24] = 24'h000000;
        flush_check("transparent_pacman", 24'hFF0000, 3'd5);

        clear_inputs();
        is_wall = 1; is_food = 1;
        DrawY = 10'(MH - 1);
        flush_check("wall_last_row", 24'h0000FF, 3'd3);
        DrawY = 10'(MH); text_bit = 1;
        flush_check("text_below_maze", 24'hFFFFFF, 3'd1);
        text_bit = 0;
        flush_check("bg_below_maze", 24'h000000, 3'd0);
        sprite_hit = 4'b1111;
        flush_check("all_transparent", 24'h000000, 3'd0);

        // Frightened-ending ghost flash with a 2-frame half-period.
        clear_inputs();
        DrawY = 10'd200;
        sprite_hit = 4'b0100;
        sprite_rgb[48 +: 24] = 24'hFFB8FF;
        frightened = 1; fright_ending = 1;
        ghost_tab[0] = 24'h2121FF; ghost_tab[1] = 24'hFFFFFF;
        ghost_tab[2] = 24'hFFFFFF; ghost_tab[3] = 24'h2121FF;
        flush_check("ghost_p0", 24'h2121FF, 3'd6);
        for (int k = 0; k < 4; k++) begin
            pulse_frame();
            flush_check($sformatf("ghost_pulse%0d", k + 1), ghost_tab[k], 3'd6);
        end
        fright_ending = 0;
        pulse_frame();
        pulse_frame();
        flush_check("ghost_fright_steady", 24'h2121FF, 3'd6);
        frightened = 0;
        flush_check("ghost_rom", 24'hFFB8FF, 3'd6);

        // Level-clear wall stream with a frame pulse mid-line; the model checks every cycle.
        clear_inputs();
        pulse_frame();
        level_clear = 1; is_wall = 1;
        for (int x = 0; x < 30; x++) begin
            pixel_valid = 1;
            DrawX = 10'(x);
            DrawY = 10'($urandom_range(0, MH - 1));
            frame_start = (x == 15);
            step();
        end
        clear_inputs();
        step();
        step();
        $display("txn level_clear_stream: 30 wall pixels, phase flip mid-line");

        // Back-to-back burst of 640 pixels.
        burst_cnt = 0;
        for (int x = 0; x < 640; x++) begin
            rand_px();
            pixel_valid = 1;
            Reset = 0;
            step();
            burst_cnt += int'(out_valid);
        end
        clear_inputs();
        for (int k = 0; k < 10; k++) begin
            step();
            burst_cnt += int'(out_valid);
        end
        check_val("burst_cnt", 32'(burst_cnt), 32'd640);
        check_val("burst_tail_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'd0);
        check_val("burst_tail_id", 32'(layer_id), 32'd0);
        $display("txn burst: %0d valid outputs", burst_cnt);

        // Random traffic with occasional frame pulses and mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            rand_px();
            frame_start = ($urandom_range(0, 19) == 0);
            Reset = ($urandom_range(0, 299) == 0);
            step();
        end
        Reset = 0;
        clear_inputs();
        step();
        step();
        step();
        $display("txn random: 3000 cycles compared against model");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
